// File: rtl/prod_accum.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : prod_accum
// Purpose  : Accumulates a block of unsigned 32-bit product beats. The beat
//            flagged with in_last closes the block, and the block result is
//            then held until the consumer accepts it.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            in_valid/in_ready - product beat handshake
//            in_prod, in_last  - product value, end-of-block marker
//            out_valid/out_ready - result handshake
//            out_sum, out_count, out_ovf - block sum, saturating beat count,
//                                          sticky overflow flag
// Config   : PROD_ACCUM_SAT_EN - when defined the accumulator saturates at
//            all-ones on overflow. When undefined it wraps modulo 2^ACC_W.
// Revision : 1.0 - initial release
// ============================================================================
module prod_accum #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  // One extra bit on the adder exposes the carry out of ACC_W.
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;

  assign sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - 32){1'b0}}, in_prod};
  assign carry   = sum_ext[ACC_W];
  assign ovf_next = ovf_q | carry;

`ifdef PROD_ACCUM_SAT_EN
  // Once overflowed the accumulator stays pinned at all-ones for the block.
  assign acc_next = ovf_next ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign acc_next = sum_ext[ACC_W-1:0];
`endif

  assign cnt_next = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      ST_ACC: begin
        // in_ready is 1 throughout ACC, so in_valid alone qualifies a beat.
        if (in_valid) begin
          acc_d = acc_next;
          cnt_d = cnt_next;
          ovf_d = ovf_next;
          if (in_last) begin
            out_sum_d   = acc_next;
            out_count_d = cnt_next;
            out_ovf_d   = ovf_next;
            state_d     = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  // Handshake outputs decode directly from the state flop.
  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_DONE);
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule
`default_nettype wire
